// File: rtl/load_store_controller.sv
// Load/store sequencer for the MEM stage: one word-aligned handshake per request,
// big-endian lane selection with sign/zero extension for loads and lane replication for stores.
//
// state | meaning
// IDLE  | waiting for Req; captures the request and checks alignment
// WAIT  | MemReq held until MemAck or wait-counter timeout
// RESP  | Done pulse; RdData/AlignErr/TimeoutErr valid
module load_store_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        IsLoad,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RdData,
    output logic        AlignErr,
    output logic        TimeoutErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWrData,
    input  logic        MemAck,
    input  logic [31:0] MemRdData
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          is_load_q, is_load_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wr_data_q, mem_wr_data_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          align_err_q, align_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic          misaligned;
    logic          timed_out;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= IDLE;
            is_load_q     <= 1'b0;
            size_q        <= 2'b00;
            unsigned_q    <= 1'b0;
            addr_lo_q     <= 2'b00;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wr_data_q <= '0;
            rd_data_q     <= '0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            is_load_q     <= is_load_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            addr_lo_q     <= addr_lo_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wr_data_q <= mem_wr_data_d;
            rd_data_q     <= rd_data_d;
            align_err_q   <= align_err_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        misaligned = (Size == 2'b11) ||
                     (Size == 2'b01 && Addr[0]) ||
                     (Size == 2'b10 && Addr[1:0] != 2'b00);
        timed_out  = (TIMEOUT != 0) && (wait_cnt_q == WAIT_TC);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Req) state_d = misaligned ? RESP : WAIT;
            WAIT: if (MemAck || timed_out) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Big-endian lanes: byte offset 0 is bits [31:24].
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = MemRdData[31:24];
            2'd1:    ld_byte = MemRdData[23:16];
            2'd2:    ld_byte = MemRdData[15:8];
            default: ld_byte = MemRdData[7:0];
        endcase
        ld_half = addr_lo_q[1] ? MemRdData[15:0] : MemRdData[31:16];
        case (size_q)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~unsigned_q}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~unsigned_q}}, ld_half};
            default: ld_ext = MemRdData;
        endcase
    end

    always_comb begin
        is_load_d     = is_load_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        addr_lo_d     = addr_lo_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wr_data_d = mem_wr_data_q;
        rd_data_d     = rd_data_q;
        align_err_d   = align_err_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            IDLE: if (Req) begin
                is_load_d  = IsLoad;
                size_d     = Size;
                unsigned_d = Unsigned;
                addr_lo_d  = Addr[1:0];
                mem_we_d   = ~IsLoad;
                mem_addr_d = {Addr[31:2], 2'b00};
                case (Size)
                    2'b00: begin
                        mem_be_d      = 4'b1000 >> Addr[1:0];
                        mem_wr_data_d = {4{WrData[7:0]}};
                    end
                    2'b01: begin
                        mem_be_d      = Addr[1] ? 4'b0011 : 4'b1100;
                        mem_wr_data_d = {2{WrData[15:0]}};
                    end
                    default: begin
                        mem_be_d      = 4'b1111;
                        mem_wr_data_d = WrData;
                    end
                endcase
                wait_cnt_d = '0;
                if (misaligned) begin
                    align_err_d   = 1'b1;
                    timeout_err_d = 1'b0;
                    rd_data_d     = '0;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WAIT: begin
                if (MemAck) begin
                    mem_req_d     = 1'b0;
                    rd_data_d     = is_load_q ? ld_ext : 32'd0;
                    align_err_d   = 1'b0;
                    timeout_err_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    if (timed_out) begin
                        mem_req_d     = 1'b0;
                        rd_data_d     = '0;
                        align_err_d   = 1'b0;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign Busy       = (state_q != IDLE);
    assign Done       = (state_q == RESP);
    assign RdData     = rd_data_q;
    assign AlignErr   = align_err_q;
    assign TimeoutErr = timeout_err_q;
    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemBe      = mem_be_q;
    assign MemWrData  = mem_wr_data_q;

endmodule

// File: tb/tb_load_store_controller.sv
// Randomized and directed checks of load_store_controller against an arithmetic
// model of big-endian lane selection, extension, byte enables and timeout.
module tb_load_store_controller;

    localparam int TIMEOUT = 4;
    localparam int NEVER   = 1000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req = 1'b0;
    logic        IsLoad = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WrData = '0;
    logic        Busy, Done, AlignErr, TimeoutErr, MemReq, MemWe;
    logic [31:0] RdData, MemAddr, MemWrData;
    logic [3:0]  MemBe;
    logic        MemAck = 1'b0;
    logic [31:0] MemRdData = '0;

    int checks = 0;
    int errors = 0;

    load_store_controller #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .IsLoad(IsLoad), .Size(Size),
        .Unsigned(Unsigned), .Addr(Addr), .WrData(WrData), .Busy(Busy),
        .Done(Done), .RdData(RdData), .AlignErr(AlignErr), .TimeoutErr(TimeoutErr),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
        .MemWrData(MemWrData), .MemAck(MemAck), .MemRdData(MemRdData)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_align_err(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (off % 2) != 0;
        if (size == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << (3 - off));
        if (size == 2'd1) return (off >= 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                           input logic [31:0] addr, input logic [31:0] w);
        int off = int'(addr % 4);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (8 * (3 - off))) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = (w >> (16 * (1 - off / 2))) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic do_txn(input bit is_load, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdw, input int ack_delay);
        bit          aerr;
        bit          acked;
        int          n_wait;
        logic [31:0] exp_rd;
        aerr   = m_align_err(size, addr);
        acked  = (ack_delay < TIMEOUT) || (TIMEOUT == 0);
        exp_rd = (aerr || !acked || !is_load) ? 32'd0 : m_load(size, uns, addr, rdw);
        Req = 1'b1; IsLoad = is_load; Size = size; Unsigned = uns; Addr = addr; WrData = wd;
        MemAck = 1'b0;
        @(negedge Clk);
        Req = 1'b0; IsLoad = $urandom; Size = 2'($urandom); Unsigned = $urandom;
        Addr = $urandom; WrData = $urandom;
        if (aerr) begin
            chk("al_busy", 32'(Busy), 32'd1);
            chk("al_memreq", 32'(MemReq), 32'd0);
            chk("al_done", 32'(Done), 32'd1);
            chk("al_err", 32'(AlignErr), 32'd1);
            chk("al_to", 32'(TimeoutErr), 32'd0);
            chk("al_rd", RdData, 32'd0);
        end else begin
            n_wait = acked ? ack_delay + 1 : TIMEOUT;
            for (int k = 0; k < n_wait; k++) begin
                chk("wait_memreq", 32'(MemReq), 32'd1);
                chk("wait_busy", 32'(Busy), 32'd1);
                chk("wait_done", 32'(Done), 32'd0);
                chk("mem_we", 32'(MemWe), 32'(!is_load));
                chk("mem_addr", MemAddr, addr - (addr % 4));
                chk("mem_be", 32'(MemBe), 32'(m_be(size, addr)));
                chk("mem_wd", MemWrData, m_wd(size, wd));
                Req = $urandom;
                if (k == ack_delay) begin
                    MemAck = 1'b1; MemRdData = rdw;
                end else begin
                    MemAck = 1'b0; MemRdData = $urandom;
                end
                @(negedge Clk);
            end
            MemAck = 1'b0;
            chk("resp_done", 32'(Done), 32'd1);
            chk("resp_memreq", 32'(MemReq), 32'd0);
            chk("resp_rd", RdData, exp_rd);
            chk("resp_al", 32'(AlignErr), 32'd0);
            chk("resp_to", 32'(TimeoutErr), 32'(!acked));
        end
        // A request presented during RESP must not be captured.
        Req = 1'b1; Size = 2'($urandom); Addr = $urandom; MemAck = $urandom;
        @(negedge Clk);
        Req = 1'b0; MemAck = 1'b0;
        chk("idle_busy", 32'(Busy), 32'd0);
        chk("idle_done", 32'(Done), 32'd0);
        chk("idle_memreq", 32'(MemReq), 32'd0);
        chk("hold_rd", RdData, exp_rd);
        chk("hold_al", 32'(AlignErr), 32'(aerr));
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_we", 32'(MemWe), 32'd0);
        chk("rst_be", 32'(MemBe), 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wd", MemWrData, 32'd0);
        chk("rst_rd", RdData, 32'd0);
        chk("rst_errs", 32'({AlignErr, TimeoutErr}), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        do_txn(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 32'h1122_33F0, 0);
        chk("lb_value", RdData, 32'hFFFF_FFF0);
        do_txn(1'b1, 2'd1, 1'b1, 32'h0000_2000, 32'd0, 32'h8001_1234, 3);
        chk("lhu_value", RdData, 32'h0000_8001);
        do_txn(1'b0, 2'd0, 1'b0, 32'h0000_3002, 32'h0000_00AB, 32'hDEAD_BEEF, 1);
        do_txn(1'b1, 2'd2, 1'b0, 32'h0000_4002, 32'd0, 32'd0, 0);
        do_txn(1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 32'd0, NEVER);
        do_txn(1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'd0, 32'hCAFE_F00D, 2);
        chk("lw_after_to", RdData, 32'hCAFE_F00D);

        // Reset in the middle of WAIT drops MemReq/Busy asynchronously.
        Req = 1'b1; IsLoad = 1'b1; Size = 2'd2; Addr = 32'h0000_7000; MemAck = 1'b0;
        @(negedge Clk);
        Req = 1'b0;
        chk("pre_rst_memreq", 32'(MemReq), 32'd1);
        #2 Rst = 1'b1;
        #1;
        chk("async_rst_memreq", 32'(MemReq), 32'd0);
        chk("async_rst_busy", 32'(Busy), 32'd0);
        chk("async_rst_done", 32'(Done), 32'd0);
        @(negedge Clk);
        chk("rst_no_done", 32'(Done), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        do_txn(1'b1, 2'd1, 1'b0, 32'h0000_7002, 32'd0, 32'h1234_8765, 0);
        chk("lh_after_rst", RdData, 32'hFFFF_8765);

        for (int t = 0; t < 300; t++) begin
            logic [1:0] sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                   int'($urandom_range(0, TIMEOUT + 1)));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                MemAck = $urandom; MemRdData = $urandom;
                @(negedge Clk);
                chk("gap_idle", 32'({Busy, MemReq, Done}), 32'd0);
            end
            MemAck = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Sequences data-memory accesses for the MEM stage: accepts one load/store request, issues a word-aligned handshake transaction to data memory, then returns the result.
- For loads, extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits (LB/LBU/LH/LHU/LW).
- For stores, drives byte enables and replicates store data across lanes (SB/SH/SW).
- Holds Busy to the pipeline hazard unit while an access is outstanding.

Parameters:
TIMEOUT, 255, maximum cycles to wait for MemAck in WAIT before aborting with TimeoutErr; 0 disables the timeout.

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
Req  input  1  access request from MEM stage; sampled only when Busy=0
IsLoad  input  1  1=load, 0=store
Size  input  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned  input  1  1=zero-extend load (LBU/LHU); ignored for word and stores
Addr  input  32  byte address
WrData  input  32  store data, right-justified
Busy  output  1  high whenever state != IDLE (combinational from state)
Done  output  1  one-cycle pulse: access complete, RdData/error flags valid
RdData  output  32  extended load result; 0 for stores and errors
AlignErr  output  1  valid with Done: misaligned or illegal Size
TimeoutErr  output  1  valid with Done: MemAck not received within TIMEOUT
MemReq  output  1  memory request, held until MemAck
MemWe  output  1  1=write
MemAddr  output  32  {Addr[31:2],2'b00}
MemBe  output  4  byte enables; bit3 = bits[31:24]
MemWrData  output  32  lane-replicated store data
MemAck  input  1  memory accepts/completes the transaction in this cycle
MemRdData  input  32  read word, valid in the cycle MemAck=1

Behaviour:
- Reset (async, any state): state=IDLE; Busy, Done, AlignErr, TimeoutErr, MemReq, MemWe = 0; RdData, MemAddr, MemWrData = 0; MemBe=0; wait counter=0. MemReq drops immediately; in-flight access is abandoned without Done.
- Memory is big-endian: Addr[1:0]=0 selects bits[31:24], 3 selects bits[7:0]. Half at Addr[1]=0 is bits[31:16].
- States: IDLE, WAIT, RESP.
- IDLE: on Req=1, register IsLoad, Size, Unsigned, Addr, WrData.
  - Misaligned (Size=01 with Addr[0]=1, Size=10 with Addr[1:0]!=0) or Size=11: go to RESP with AlignErr set; no memory transaction.
  - Otherwise: go to WAIT and drive MemReq=1 with MemWe=~IsLoad, MemAddr, MemBe, MemWrData.
- MemBe by size:
  - byte: one-hot 4'b1000>>Addr[1:0].
  - half: 1100 (Addr[1]=0) or 0011 (Addr[1]=1).
  - word: 1111.
  - Loads drive the same MemBe.
- MemWrData by size: byte {4{WrData[7:0]}}; half {2{WrData[15:0]}}; word WrData.
- WAIT:
  - MemReq and all Mem* outputs are held stable.
  - On MemAck=1: capture the extended load value into RdData (0 for stores), drop MemReq, go to RESP.
  - Otherwise increment the wait counter. When TIMEOUT!=0 and the counter reaches TIMEOUT without MemAck: drop MemReq, set TimeoutErr, go to RESP.
- RESP: Done=1 for exactly one cycle with RdData/AlignErr/TimeoutErr valid; next state IDLE. RdData, AlignErr and TimeoutErr hold their values until the next Done.
- Extension: byte = {{24{b[7]&~Unsigned}}, b}; half = {{16{h[15]&~Unsigned}}, h}; word passes through.
- Latency: minimum Req-to-Done is 2 cycles (Req at edge 0, MemReq high cycle 1 with MemAck=1, Done cycle 2). Misaligned Req-to-Done is 1 cycle.
- Back-to-back: Req is ignored while Busy=1; a new request is accepted in the IDLE cycle following RESP. A Req present during RESP is not captured.
- MemAck outside WAIT is ignored.

Test Plan:
- LB, Addr=0x1003, MemRdData=0x1122_33F0, ack 1st cycle -> MemAddr=0x1000, MemBe=0001, MemWe=0, Done at cycle 2, RdData=0xFFFF_FFF0.
- LHU, Addr=0x2000, MemRdData=0x8001_1234, ack after 3 wait cycles -> MemBe=1100, MemReq held 4 cycles, RdData=0x0000_8001.
- SB, Addr=0x3002, WrData=0x0000_00AB -> MemWe=1, MemBe=0010, MemWrData=0xABAB_ABAB, Done with RdData=0.
- LW, Addr=0x4002 -> no MemReq ever asserted, Done next cycle with AlignErr=1, RdData=0.
- TIMEOUT=4, LW Addr=0x5000, MemAck held 0 -> MemReq high exactly 4 cycles, then Done with TimeoutErr=1; next Req accepted normally.
- Rst asserted mid-WAIT -> MemReq and Busy drop immediately without a clock edge, no Done pulse; Req after reset release is serviced with correct values.
